// File: rtl/memory_unit.sv
// Memory subsystem for the basic processor: MAR, MDR, a 32-word synchronous RAM,
// one memory-mapped I/O word at the top address, and a program-load port.
module memory_unit #(
  parameter  int WORD_W = 8,
  parameter  int OP_W   = 3,
  localparam int ADDR_W = WORD_W - OP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] sysbus,
  input  logic              load_MAR,
  input  logic              load_MDR,
  input  logic              MDR_bus,
  input  logic              CS,
  input  logic              R_NW,
  output logic [WORD_W-1:0] mdr_out,
  input  logic [WORD_W-1:0] in_port,
  output logic [WORD_W-1:0] out_port,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  output logic              prog_err
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IO_ADDR = {ADDR_W{1'b1}};

  logic [ADDR_W-1:0] mar_r;
  logic [WORD_W-1:0] mdr_r;
  logic [WORD_W-1:0] out_port_r;
  logic [WORD_W-1:0] sync1_r;
  logic [WORD_W-1:0] sync2_r;
  logic              prog_err_r;

  logic [WORD_W-1:0] mem [DEPTH];

  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [WORD_W-1:0] ram_wdata_s;
  logic              out_we_s;
  logic [WORD_W-1:0] out_wdata_s;
  logic [WORD_W-1:0] read_data_s;
  logic              mar_io_s;
  logic              prog_io_s;

  assign mar_io_s  = (mar_r == IO_ADDR);
  assign prog_io_s = (prog_addr == IO_ADDR);

  // Read mux: the I/O address returns the synchronised input, never the RAM cell.
  always_comb begin
    read_data_s = mem[mar_r];
    if (mar_io_s) begin
      read_data_s = sync2_r;
    end else begin
      read_data_s = mem[mar_r];
    end
  end

  // Write steering: a CS access always takes priority over the program-load port.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = mar_r;
    ram_wdata_s = mdr_r;
    out_we_s    = 1'b0;
    out_wdata_s = mdr_r;
    if (CS) begin
      if (!R_NW) begin
        if (mar_io_s) begin
          out_we_s = 1'b1;
        end else begin
          ram_we_s = 1'b1;
        end
      end else begin
        ram_we_s = 1'b0;
      end
    end else if (prog_we) begin
      if (prog_io_s) begin
        out_we_s    = 1'b1;
        out_wdata_s = prog_data;
      end else begin
        ram_we_s    = 1'b1;
        ram_waddr_s = prog_addr;
        ram_wdata_s = prog_data;
      end
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Control registers; read data into MDR beats a concurrent load_MDR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mar_r      <= {ADDR_W{1'b0}};
      mdr_r      <= {WORD_W{1'b0}};
      out_port_r <= {WORD_W{1'b0}};
      sync1_r    <= {WORD_W{1'b0}};
      sync2_r    <= {WORD_W{1'b0}};
      prog_err_r <= 1'b0;
    end else begin
      sync1_r    <= in_port;
      sync2_r    <= sync1_r;
      prog_err_r <= prog_we & CS;
      if (load_MAR) begin
        mar_r <= sysbus[ADDR_W-1:0];
      end
      if (CS && R_NW) begin
        mdr_r <= read_data_s;
      end else if (load_MDR) begin
        mdr_r <= sysbus;
      end
      if (out_we_s) begin
        out_port_r <= out_wdata_s;
      end
    end
  end

  // RAM array: contents survive reset, but no write lands on an edge with reset high.
  always_ff @(posedge clock) begin
    if (ram_we_s && !reset) begin
      mem[ram_waddr_s] <= ram_wdata_s;
    end
  end

  assign mdr_out  = MDR_bus ? mdr_r : {WORD_W{1'b0}};
  assign out_port = out_port_r;
  assign prog_err = prog_err_r;

endmodule
